uart_pop_receiver: RTL

//  UART (8N1) receive end of the population link that the UART spitter drives.
//  - Deserialises a byte stream into a POP_WIDTH-bit population word (default: 10 paths x 150 b).
//  - Lets the host load or inject a selected population into the GA state machine.
//  - Sits beside the State module: State pulses start, then consumes population when done pulses.

---
 rtl/uart_pop_receiver.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_pop_receiver.sv
// 8N1 UART receiver that assembles a POP_WIDTH-bit population word from a byte stream.
// A start pulse arms one transfer; done pulses when the final byte lands in population.
module uart_pop_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int POP_WIDTH    = 1500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx,
    output logic [POP_WIDTH-1:0] population,
    output logic                 done,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int NUM_BYTES = (POP_WIDTH + 7) / 8;
    localparam int SHW       = 8 * NUM_BYTES;
    localparam int TW        = $clog2(CLKS_PER_BIT);
    localparam int CW        = $clog2(NUM_BYTES + 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_B = CW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bstate_t;
    typedef enum logic {T_IDLE, T_RECV} tstate_t;

    logic                 sync_q, rx_s_q;
    bstate_t              bstate_q, bstate_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bitidx_q, bitidx_d;
    logic [7:0]           data_q, data_d;
    tstate_t              tstate_q, tstate_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SHW-1:0]       shadow_q, shadow_d;
    logic [POP_WIDTH-1:0] pop_q, pop_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 byte_valid, byte_err;

    // Bit-level framing: start-bit midpoint check, then one sample per bit period.
    always_comb begin
        bstate_d   = bstate_q;
        timer_d    = timer_q + 1'b1;
        bitidx_d   = bitidx_q;
        data_d     = data_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                timer_d = '0;
                if (!rx_s_q) bstate_d = B_START;
            end
            B_START: begin
                if (timer_q == HALF_T) begin
                    timer_d  = '0;
                    bitidx_d = '0;
                    bstate_d = rx_s_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (timer_q == LAST_T) begin
                    timer_d  = '0;
                    data_d   = {rx_s_q, data_q[7:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) bstate_d = B_STOP;
                end
            end
            B_STOP: begin
                if (timer_q == LAST_T) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                        bstate_d   = B_IDLE;
                    end else begin
                        byte_err = 1'b1;
                        bstate_d = B_BREAK;
                    end
                end
            end
            B_BREAK: begin
                // A line held low after a bad stop bit must not look like a new start bit.
                timer_d = '0;
                if (rx_s_q) bstate_d = B_IDLE;
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    // Transfer control: byte counter, shadow assembly and the population commit.
    always_comb begin
        tstate_d = tstate_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        pop_d    = pop_q;
        done_d   = 1'b0;
        ferr_d   = ferr_q;
        case (tstate_q)
            T_IDLE: begin
                if (start && !done_q) begin
                    tstate_d = T_RECV;
                    cnt_d    = '0;
                    ferr_d   = 1'b0;
                end
            end
            T_RECV: begin
                if (byte_err) begin
                    ferr_d   = 1'b1;
                    tstate_d = T_IDLE;
                end else if (byte_valid) begin
                    shadow_d[8*cnt_q +: 8] = data_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_B) begin
                        pop_d    = shadow_d[POP_WIDTH-1:0];
                        done_d   = 1'b1;
                        tstate_d = T_IDLE;
                    end
                end
            end
            default: tstate_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            bstate_q <= B_IDLE;
            timer_q  <= '0;
            bitidx_q <= '0;
            tstate_q <= T_IDLE;
            cnt_q    <= '0;
            pop_q    <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync_q   <= rx;
            rx_s_q   <= sync_q;
            bstate_q <= bstate_d;
            timer_q  <= timer_d;
            bitidx_q <= bitidx_d;
            tstate_q <= tstate_d;
            cnt_q    <= cnt_d;
            pop_q    <= pop_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    // Datapath holding registers carry no reset; population only ever sees them on done.
    always_ff @(posedge clk) begin
        data_q   <= data_d;
        shadow_q <= shadow_d;
    end

    assign population = pop_q;
    assign done       = done_q;
    assign busy       = (tstate_q == T_RECV);
    assign frame_err  = ferr_q;
endmodule
